// File: rtl/int_divider_seq_if.sv
// Operation and result handshake bundle for int_divider_seq.
// The master side is the reservation station / result consumer; the slave side is the divider.
interface int_divider_seq_if #(
    parameter int W     = 64,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_dividend;
    logic [W-1:0]     in_divisor;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_quotient;
    logic [W-1:0]     out_remainder;
    logic [TAG_W-1:0] out_tag;
    logic             out_div_zero;

    modport master (
        output in_valid, in_dividend, in_divisor, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_tag, out_div_zero
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_tag, out_div_zero
    );
endinterface

// File: rtl/int_divider_seq.sv
// Iterative restoring divider, one quotient bit per clock, single operation in flight.
// Define INT_DIV_SIGNED_EN to build signed division (magnitude divide plus a FIX cycle).
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// BUSY  | shifting/subtracting, W iterations (1 cycle for a zero divisor)
// FIX   | sign correction of quotient/remainder (signed build only)
// DONE  | out_valid high, result held until out_ready
module int_divider_seq #(
    parameter int W     = 64,
    parameter int TAG_W = 6
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    int_divider_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [W-1:0] CNT_LAST = W'(W - 1);

    logic [1:0]       state;
    logic [W-1:0]     cnt;
    logic [W-1:0]     rem;
    logic [W-1:0]     quo;
    logic [W-1:0]     dsr;
    logic [TAG_W-1:0] tag_q;

    logic [W-1:0]     res_quotient;
    logic [W-1:0]     res_remainder;
    logic [TAG_W-1:0] res_tag;
    logic             res_div_zero;

    logic [W:0]       rem_sh;
    logic [W:0]       rem_sub;
    logic [W-1:0]     rem_nx;
    logic [W-1:0]     quo_nx;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic             div_by_zero_in;

`ifdef INT_DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;
    logic neg_r;
`endif

    // The W+1-bit subtraction borrow doubles as the "rem >= divisor" compare.
    always_comb begin
        rem_sh  = {rem, quo[W-1]};
        rem_sub = rem_sh - {1'b0, dsr};
        if (!rem_sub[W]) begin
            rem_nx = rem_sub[W-1:0];
            quo_nx = {quo[W-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[W-1:0];
            quo_nx = {quo[W-2:0], 1'b0};
        end
    end

    always_comb begin
        div_by_zero_in = (bus.in_divisor == '0);
`ifdef INT_DIV_SIGNED_EN
        a_neg = bus.in_signed & bus.in_dividend[W-1];
        b_neg = bus.in_signed & bus.in_divisor[W-1];
        a_mag = a_neg ? (~bus.in_dividend + W'(1)) : bus.in_dividend;
        b_mag = b_neg ? (~bus.in_divisor + W'(1)) : bus.in_divisor;
`else
        a_mag = bus.in_dividend;
        b_mag = bus.in_divisor;
`endif
        // A zero divisor returns the raw dividend as the remainder.
        if (div_by_zero_in) begin
            a_mag = bus.in_dividend;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dsr           <= '0;
            tag_q         <= '0;
            res_quotient  <= '0;
            res_remainder <= '0;
            res_tag       <= '0;
            res_div_zero  <= 1'b0;
`ifdef INT_DIV_SIGNED_EN
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
`endif
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        quo   <= a_mag;
                        dsr   <= b_mag;
                        rem   <= '0;
                        cnt   <= '0;
                        tag_q <= bus.in_tag;
`ifdef INT_DIV_SIGNED_EN
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
`endif
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (dsr == '0) begin
                        res_quotient  <= '1;
                        res_remainder <= quo;
                        res_tag       <= tag_q;
                        res_div_zero  <= 1'b1;
                        state         <= DONE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + W'(1);
                        if (cnt == CNT_LAST) begin
`ifdef INT_DIV_SIGNED_EN
                            if (neg_q || neg_r) begin
                                state <= FIX;
                            end else begin
                                res_quotient  <= quo_nx;
                                res_remainder <= rem_nx;
                                res_tag       <= tag_q;
                                res_div_zero  <= 1'b0;
                                state         <= DONE;
                            end
`else
                            res_quotient  <= quo_nx;
                            res_remainder <= rem_nx;
                            res_tag       <= tag_q;
                            res_div_zero  <= 1'b0;
                            state         <= DONE;
`endif
                        end
                    end
                end
`ifdef INT_DIV_SIGNED_EN
                FIX: begin
                    res_quotient  <= neg_q ? (~quo + W'(1)) : quo;
                    res_remainder <= neg_r ? (~rem + W'(1)) : rem;
                    res_tag       <= tag_q;
                    res_div_zero  <= 1'b0;
                    state         <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = (state == DONE);
    assign bus.out_quotient  = res_quotient;
    assign bus.out_remainder = res_remainder;
    assign bus.out_tag       = res_tag;
    assign bus.out_div_zero  = res_div_zero;
endmodule

// File: tb/tb_int_divider_seq.sv
// Scoreboard bench for int_divider_seq: results, latency, hold, flush and reset behaviour.
module tb_int_divider_seq;
    localparam int W     = 64;
    localparam int TAG_W = 6;
    localparam int LIMIT = 200;

    typedef struct packed {
        logic [W-1:0]     q;
        logic [W-1:0]     r;
        logic [TAG_W-1:0] tag;
        logic             dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    int_divider_seq_if #(.W(W), .TAG_W(TAG_W)) bus ();

    int_divider_seq #(.W(W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        e.tag = tag;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t g;
        g.q   = bus.out_quotient;
        g.r   = bus.out_remainder;
        g.tag = bus.out_tag;
        g.dz  = bus.out_div_zero;
        return g;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic sgn);
        bus.in_dividend = a;
        bus.in_divisor  = b;
        bus.in_tag      = tag;
        bus.in_signed   = sgn;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        exp_t g;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        g = observed();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || g !== '0) begin
            failures++;
            $display("FAIL reset_state in_ready=%b out_valid=%b q=%h r=%h tag=%0d dz=%b, want 1 0 all zero",
                     bus.in_ready, bus.out_valid, g.q, g.r, g.tag, g.dz);
        end
    endtask

    task automatic test_basic();
        int lat;
        exp_t e, g;
        sb.push_back('{q: 64'd8, r: 64'd0, tag: 6'd5, dz: 1'b0});
        issue(64'd80, 64'd10, 6'd5, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 64) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=64", lat);
        end
        e = sb.pop_front();
        g = observed();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL basic_result got q=%h r=%h tag=%0d dz=%b want q=%h r=%h tag=%0d dz=%b",
                     g.q, g.r, g.tag, g.dz, e.q, e.r, e.tag, e.dz);
        end
        retire();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready_after got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_large_divisor();
        int lat;
        exp_t e, g;
        sb.push_back('{q: 64'd1, r: 64'h7FFF_FFFF_FFFF_FFFF, tag: 6'd33, dz: 1'b0});
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 6'd33, 1'b0);
        wait_out(lat);
        e = sb.pop_front();
        g = observed();
        checks++;
        if (lat !== 64 || g !== e) begin
            failures++;
            $display("FAIL large_divisor lat=%0d q=%h r=%h want lat=64 q=%h r=%h", lat, g.q, g.r, e.q, e.r);
        end
        retire();
    endtask

    task automatic test_div_zero();
        int lat;
        exp_t e, g;
        sb.push_back('{q: 64'hFFFF_FFFF_FFFF_FFFF, r: 64'd1234, tag: 6'd17, dz: 1'b1});
        issue(64'd1234, 64'd0, 6'd17, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL div_zero_latency got=%0d want=1", lat);
        end
        e = sb.pop_front();
        g = observed();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL div_zero_result got q=%h r=%h tag=%0d dz=%b want q=%h r=%h tag=%0d dz=%b",
                     g.q, g.r, g.tag, g.dz, e.q, e.r, e.tag, e.dz);
        end
        retire();
    endtask

    task automatic test_hold();
        int lat;
        exp_t e, g, snap;
        sb.push_back(model(64'd12345, 64'd67, 6'd3));
        issue(64'd12345, 64'd67, 6'd3, 1'b0);
        wait_out(lat);
        snap = observed();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            g = observed();
            checks++;
            if (g !== snap || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d q=%h r=%h in_ready=%b out_valid=%b want q=%h r=%h 0 1",
                         i, g.q, g.r, bus.in_ready, bus.out_valid, snap.q, snap.r);
            end
        end
        e = sb.pop_front();
        checks++;
        if (snap !== e) begin
            failures++;
            $display("FAIL hold_result got q=%h r=%h want q=%h r=%h", snap.q, snap.r, e.q, e.r);
        end
        retire();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_release in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_flush();
        int lat;
        logic seen;
        exp_t e, g;
        issue(64'd1000, 64'd3, 6'd1, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_result out_valid_seen=%b want 0", seen);
        end
        sb.push_back('{q: 64'd14, r: 64'd2, tag: 6'd9, dz: 1'b0});
        issue(64'd100, 64'd7, 6'd9, 1'b0);
        wait_out(lat);
        e = sb.pop_front();
        g = observed();
        checks++;
        if (lat !== 64 || g !== e) begin
            failures++;
            $display("FAIL flush_next_op lat=%0d q=%h r=%h tag=%0d want lat=64 q=%h r=%h tag=%0d",
                     lat, g.q, g.r, g.tag, e.q, e.r, e.tag);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a_tab [8];
        logic [W-1:0] b_tab [8];
        int lat;
        exp_t e, g;
        logic [TAG_W-1:0] tag;
        a_tab = '{64'd0, 64'd5, 64'd99, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'd42, {$urandom, $urandom}, {$urandom, $urandom}};
        b_tab = '{64'd9, 64'd9, 64'd99, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE,
                  64'd0, {32'd0, $urandom}, 64'd3};
        for (int i = 0; i < 8; i++) begin
            tag = TAG_W'($urandom_range(63, 0));
            sb.push_back(model(a_tab[i], b_tab[i], tag));
            issue(a_tab[i], b_tab[i], tag, 1'b0);
            wait_out(lat);
            e = sb.pop_front();
            g = observed();
            checks++;
            if (lat !== (e.dz ? 1 : 64) || g !== e) begin
                failures++;
                $display("FAIL b2b_op%0d lat=%0d q=%h r=%h tag=%0d dz=%b want q=%h r=%h tag=%0d dz=%b",
                         i, lat, g.q, g.r, g.tag, g.dz, e.q, e.r, e.tag, e.dz);
            end
            retire();
        end
    endtask

`ifdef INT_DIV_SIGNED_EN
    task automatic test_signed();
        int lat;
        exp_t e, g;
        sb.push_back('{q: -64'sd3, r: -64'sd1, tag: 6'd11, dz: 1'b0});
        issue(-64'sd7, 64'd2, 6'd11, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        g = observed();
        checks++;
        if (lat !== 65 || g !== e) begin
            failures++;
            $display("FAIL signed_neg7_div2 lat=%0d q=%h r=%h want lat=65 q=%h r=%h", lat, g.q, g.r, e.q, e.r);
        end
        retire();
        sb.push_back('{q: 64'h8000_0000_0000_0000, r: 64'd0, tag: 6'd12, dz: 1'b0});
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd12, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        g = observed();
        checks++;
        if (lat !== 65 || g !== e) begin
            failures++;
            $display("FAIL signed_min_div_m1 lat=%0d q=%h r=%h dz=%b want lat=65 q=%h r=%h dz=0",
                     lat, g.q, g.r, g.dz, e.q, e.r);
        end
        retire();
    endtask
`else
    task automatic test_signed();
        int lat;
        exp_t e, g;
        sb.push_back(model(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd11));
        issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd11, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        g = observed();
        checks++;
        if (lat !== 64 || g !== e) begin
            failures++;
            $display("FAIL signed_ignored lat=%0d q=%h r=%h want lat=64 q=%h r=%h", lat, g.q, g.r, e.q, e.r);
        end
        retire();
    endtask
`endif

    task automatic test_reset_mid_op();
        exp_t g;
        logic seen;
        issue(64'd500, 64'd7, 6'd2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        g = observed();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || g !== '0) begin
            failures++;
            $display("FAIL reset_mid_op in_ready=%b out_valid=%b q=%h r=%h tag=%0d dz=%b want 1 0 all zero",
                     bus.in_ready, bus.out_valid, g.q, g.r, g.tag, g.dz);
        end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_result out_valid_seen=%b want 0", seen);
        end
    endtask

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.in_signed   = 1'b0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_large_divisor();
        test_div_zero();
        test_hold();
        test_flush();
        test_back_to_back();
        test_signed();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
